sub16_iter: RTL and testbench
=============================

Name: sub16_iter

Overview:
- Multi-cycle 16-bit subtractor, the inverse operation of the team's ripple-carry adder datapath: computes d = x - y - bin.
- Processes one 4-bit slice per clock, LSB slice first, with the borrow held in a register between slices.
- Operands come in and results go out over valid/ready handshakes.
- Sits beside the adder in the arithmetic test datapath and is the reference subtract path for the self-checking benches.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSL = WIDTH/SLICE slices (4 at defaults).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operands x, y, bin are valid.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  minuend.
- y  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference, modulo 2^WIDTH.
- bo  output  1  borrow out; 1 when unsigned x < y + bin.
- ovf  output  1  signed overflow; two's-complement x - y - bin is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, d=0, bo=0, ovf=0, slice index=0, borrow register=0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch x, y, bin; load borrow register with bin; set index=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: diff = {1'b0, x_slice[idx]} - y_slice[idx] - borrow (SLICE+1 bits).
  - d slice idx <= diff[SLICE-1:0]; borrow <= diff[SLICE]; idx <= idx+1.
  - On the slice with idx = NSL-1: bo <= final borrow; ovf <= (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]) using the new MSB; go to DONE.
- DONE:
  - out_valid=1, in_ready=0; d, bo, ovf held stable.
  - On an edge with out_ready=1: go to IDLE, clear out_valid. d, bo, ovf keep their values until the next result overwrites them.
- Latency: the accept edge is edge 0; out_valid rises after edge NSL (4 at defaults). Minimum throughput is one operation per NSL+2 cycles. No overlap of operations.
- Operands are sampled only at accept; changes to x, y, bin during RUN/DONE have no effect.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- out_valid stays asserted indefinitely under backpressure; the result does not change.
- Wrap-around: 0 - 1 gives d=0xFFFF, bo=1. 0 - 0xFFFF - 1 gives d=0x0000, bo=1.
- Reset asserted mid-RUN or in DONE: aborts the operation, returns to the reset values next edge, and no out_valid pulse is produced. Reset has priority over every handshake.
- Combinational paths: in_ready and out_valid are decoded from state only; no input-to-output combinational path.

Optional Feature:
- Macro SUB16_ZERO_FLAG_EN.
- Defined:
  - Adds output port zf (1 bit): 1 when the final d == 0.
  - zf is registered with bo/ovf and valid with out_valid.
  - zf resets to 0.
- Undefined: no zf port; all other behaviour identical.

Test Plan:
- Basic: reset 2 cycles; x=0x1234, y=0x0234, bin=0 -> out_valid rises exactly 4 edges after accept; d=0x1000, bo=0, ovf=0 (zf=0).
- Underflow: x=0x0000, y=0x0001, bin=0 -> d=0xFFFF, bo=1, ovf=0.
- Signed overflow: x=0x8000, y=0x0001, bin=0 -> d=0x7FFF, bo=0, ovf=1. Also x=0x7FFF, y=0xFFFF -> d=0x8000, bo=1, ovf=1.
- Borrow-in and zero: x=0x0000, y=0xFFFF, bin=1 -> d=0x0000, bo=1, ovf=0, zf=1 when SUB16_ZERO_FLAG_EN is defined.
- Handshake: hold out_ready=0 for 10 cycles -> out_valid and d stable, in_ready=0, second in_valid ignored. Then raise out_ready -> one-cycle transfer, in_ready=1 the next cycle, queued operand (x=0x0010, y=0x0001) accepted and gives d=0x000F.
- Reset mid-op: deassert rst_n two cycles after accepting x=0xFFFF, y=0x0001 -> next edge out_valid=0, in_ready=1, d=0, bo=0. No result is ever presented for the aborted operation.

Source files
------------

// File: rtl/sub16_iter.sv
// sub16_iter: multi-cycle subtractor computing d = x - y - bin, one SLICE-bit
// slice per clock (LSB slice first), with the inter-slice borrow registered.
//
// Optional feature macro: SUB16_ZERO_FLAG_EN adds the zf output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands x, y, bin are valid
//   in_ready   block can accept operands (IDLE)
//   x, y       minuend, subtrahend (WIDTH bits)
//   bin        borrow in
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   d          difference modulo 2^WIDTH
//   bo         borrow out (unsigned x < y + bin)
//   ovf        two's-complement overflow of x - y - bin
//   zf         (SUB16_ZERO_FLAG_EN only) final d == 0
module sub16_iter #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf
`ifdef SUB16_ZERO_FLAG_EN
    ,
    output logic             zf
`endif
);

    localparam int NSL  = WIDTH / SLICE;
    localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic             bo_q, bo_d;
    logic             ovf_q, ovf_d;
`ifdef SUB16_ZERO_FLAG_EN
    logic             zf_q, zf_d;
`endif

    logic [SLICE:0]   diff;
    int unsigned      lo;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        d_d      = d_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        ovf_d    = ovf_q;
`ifdef SUB16_ZERO_FLAG_EN
        zf_d     = zf_q;
`endif
        diff     = '0;
        lo       = idx_q * SLICE;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d      = x;
                    y_d      = y;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Zero-extended slice subtract: the extra top bit is the borrow.
                diff = {1'b0, x_q[lo +: SLICE]} - {1'b0, y_q[lo +: SLICE]}
                     - {{SLICE{1'b0}}, borrow_q};
                d_d[lo +: SLICE] = diff[SLICE-1:0];
                borrow_d = diff[SLICE];
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    bo_d    = diff[SLICE];
                    // Uses the freshly computed MSB of d, not the stale register.
                    ovf_d   = (x_q[WIDTH-1] != y_q[WIDTH-1]) &&
                              (d_d[WIDTH-1] != x_q[WIDTH-1]);
`ifdef SUB16_ZERO_FLAG_EN
                    zf_d    = (d_d == '0);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            d_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SUB16_ZERO_FLAG_EN
            zf_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            d_q      <= d_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            ovf_q    <= ovf_d;
`ifdef SUB16_ZERO_FLAG_EN
            zf_q     <= zf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bo        = bo_q;
    assign ovf       = ovf_q;
`ifdef SUB16_ZERO_FLAG_EN
    assign zf        = zf_q;
`endif

endmodule

// File: tb/tb_sub16_iter.sv
module tb_sub16_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bo;
    logic        ovf;
`ifdef SUB16_ZERO_FLAG_EN
    logic        zf;
`endif

    int tests = 0;
    int fails = 0;

    sub16_iter #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo),
        .ovf       (ovf)
`ifdef SUB16_ZERO_FLAG_EN
        ,
        .zf        (zf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on the whole operands.
    function automatic void model(input logic [15:0] mx, input logic [15:0] my,
                                  input logic mb, output logic [15:0] md,
                                  output logic mbo, output logic movf,
                                  output logic mzf);
        int ux, uy, sx, sy, sd;
        ux = int'(mx);
        uy = int'(my);
        sx = int'($signed(mx));
        sy = int'($signed(my));
        sd = sx - sy - int'(mb);
        md   = 16'(ux - uy - int'(mb));
        mbo  = (ux < uy + int'(mb));
        movf = (sd < -32768) || (sd > 32767);
        mzf  = (md == 16'h0000);
    endfunction

    function automatic logic get_zf();
`ifdef SUB16_ZERO_FLAG_EN
        return zf;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one full transaction; lat is -1 when a bound expires.
    task automatic run_op(input logic [15:0] ox, input logic [15:0] oy, input logic ob,
                          output logic [15:0] rd, output logic rbo, output logic rovf,
                          output logic rzf, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        x = ox; y = oy; bin = ob; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands after accept; they must have no effect.
        x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) lat = -1;
        rd = d; rbo = bo; rovf = ovf; rzf = get_zf();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, d, bo, ovf, get_zf()} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b d=%h bo=%b ovf=%b zf=%b required 1 0 0000 0 0 0",
                     in_ready, out_valid, d, bo, ovf, get_zf());
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] vx [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000};
        logic [15:0] vy [5] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
        logic        vb [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ed [5] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        logic        eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        ez [5];
        logic [15:0] rd;
        logic        rbo, rovf, rzf;
        int          lat;
`ifdef SUB16_ZERO_FLAG_EN
        ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            run_op(vx[i], vy[i], vb[i], rd, rbo, rovf, rzf, lat);
            tests++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL directed%0d latency: got %0d required 4", i, lat);
            end
            tests++;
            if ({rd, rbo, rovf, rzf} !== {ed[i], eb[i], eo[i], ez[i]}) begin
                fails++;
                $display("FAIL directed%0d result: d=%h bo=%b ovf=%b zf=%b required d=%h bo=%b ovf=%b zf=%b",
                         i, rd, rbo, rovf, rzf, ed[i], eb[i], eo[i], ez[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        x = 16'h1111; y = 16'h0111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        // Queue a second operand that must be ignored until IDLE.
        x = 16'h0010; y = 16'h0001; bin = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL bp_latency: got %0d required 4", n);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({out_valid, in_ready, d, bo, ovf} !== {1'b1, 1'b0, 16'h1000, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b d=%h bo=%b ovf=%b required 1 0 1000 0 0",
                         i, out_valid, in_ready, d, bo, ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if ({n, d, bo, ovf} !== {32'd4, 16'h000F, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bp_queued: lat=%0d d=%h bo=%b ovf=%b required lat=4 d=000f bo=0 ovf=0",
                     n, d, bo, ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        x = 16'hFFFF; y = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, in_ready, d, bo, ovf} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b d=%h bo=%b ovf=%b required 0 1 0000 0 0",
                     out_valid, in_ready, d, bo, ovf);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_result: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [15:0] rx, ry, rd, md;
        logic        rb, rbo, rovf, rzf, mbo, movf, mzf;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rb = 1'($urandom);
            if (i % 8 == 0) ry = rx;  // exercise zero results
            model(rx, ry, rb, md, mbo, movf, mzf);
`ifndef SUB16_ZERO_FLAG_EN
            mzf = 1'b0;
`endif
            run_op(rx, ry, rb, rd, rbo, rovf, rzf, lat);
            tests++;
            if ({lat, rd, rbo, rovf, rzf} !== {32'd4, md, mbo, movf, mzf}) begin
                fails++;
                $display("FAIL random%0d x=%h y=%h bin=%b: lat=%0d d=%h bo=%b ovf=%b zf=%b required lat=4 d=%h bo=%b ovf=%b zf=%b",
                         i, rx, ry, rb, lat, rd, rbo, rovf, rzf, md, mbo, movf, mzf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
